// File: rtl/cam_pkg.sv
// Shared constants, FSM encoding and pipeline record for the camera capture block.
package cam_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned OUT_PIX  = 76800;
  localparam int unsigned ADDR_W   = 17;

  // Row/column counters saturate instead of wrapping so oversized frames stay out of range.
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] SYNC_WAIT  = 2'd0;
  localparam logic [1:0] FRAME_WAIT = 2'd1;
  localparam logic [1:0] ACTIVE     = 2'd2;

  typedef struct packed {
    logic        keep;
    logic [15:0] pix;
  } cam_pix_t;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer for one camera control line, with rise/fall detect on the synced copy.
module cam_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_ff1;
  logic r_ff2;
  logic r_ff3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
      r_ff3 <= 1'b0;
    end else begin
      r_ff1 <= i_async;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
    end
  end

  assign o_sync = r_ff2;
  assign o_rise = r_ff2 & ~r_ff3;
  assign o_fall = ~r_ff2 & r_ff3;

endmodule

// File: rtl/cam_capture.sv
// Captures an RGB565 byte-stream camera into a 2:1 decimated frame buffer write stream.
module cam_capture #(
  parameter int unsigned H_ACTIVE = cam_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = cam_pkg::V_ACTIVE,
  parameter int unsigned OUT_PIX  = cam_pkg::OUT_PIX,
  parameter int unsigned ADDR_W   = cam_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [15:0]       pix_data,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic              vsync_out,
  output logic              frame_done,
  output logic              overflow
);

  import cam_pkg::*;

  logic [7:0]       r_data_ff1;
  logic [7:0]       r_data_ff2;
  logic             w_pclk_sync;
  logic             w_pclk_rise;
  logic             w_pclk_fall;
  logic             w_href;
  logic             w_href_rise;
  logic             w_href_fall;
  logic             w_vs_sync;
  logic             w_vs_rise;
  logic             w_vs_fall;
  logic             w_unused;

  logic [1:0]       r_state;
  logic             r_phase;
  logic [7:0]       r_hi;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  cam_pix_t         r_s1;
  cam_pix_t         r_s2;
  logic             r_frame_done;
  logic             r_wen;
  logic [15:0]      r_pix;
  logic [ADDR_W-1:0] r_waddr;
  logic             r_overflow;

  logic             w_keep;
  logic             w_addr_full;
  logic             w_enter_active;

  cam_sync u_sync_pclk (
    .clk    (clk),
    .reset  (reset),
    .i_async(cam_pclk),
    .o_sync (w_pclk_sync),
    .o_rise (w_pclk_rise),
    .o_fall (w_pclk_fall)
  );

  cam_sync u_sync_href (
    .clk    (clk),
    .reset  (reset),
    .i_async(cam_href),
    .o_sync (w_href),
    .o_rise (w_href_rise),
    .o_fall (w_href_fall)
  );

  cam_sync u_sync_vsync (
    .clk    (clk),
    .reset  (reset),
    .i_async(cam_vsync),
    .o_sync (w_vs_sync),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  assign w_unused = w_pclk_sync ^ w_pclk_fall ^ w_href_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_ff1 <= '0;
      r_data_ff2 <= '0;
    end else begin
      r_data_ff1 <= cam_data;
      r_data_ff2 <= r_data_ff1;
    end
  end

  assign w_keep = !r_col[0] && !r_row[0] &&
                  (r_col < CNT_W'(H_ACTIVE)) && (r_row < CNT_W'(V_ACTIVE));
  assign w_enter_active = (r_state == FRAME_WAIT) && w_vs_fall;
  assign w_addr_full    = (r_waddr == ADDR_W'(OUT_PIX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SYNC_WAIT;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_s1         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_s1.keep    <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        SYNC_WAIT: begin
          if (w_vs_rise) r_state <= FRAME_WAIT;
        end
        FRAME_WAIT: begin
          if (w_vs_fall) begin
            r_state <= ACTIVE;
            r_phase <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        ACTIVE: begin
          // vsync wins over any byte arriving in the same cycle; a half pixel is dropped.
          if (w_vs_rise) begin
            r_state      <= FRAME_WAIT;
            r_frame_done <= 1'b1;
            r_phase      <= 1'b0;
          end else if (!w_href) begin
            r_phase <= 1'b0;
            if (w_href_fall) begin
              r_col <= '0;
              r_row <= (r_row == '1) ? r_row : r_row + CNT_W'(1);
            end
          end else if (w_pclk_rise) begin
            if (!r_phase) begin
              r_hi    <= r_data_ff2;
              r_phase <= 1'b1;
            end else begin
              r_phase   <= 1'b0;
              r_s1.keep <= w_keep;
              r_s1.pix  <= {r_hi, r_data_ff2};
              r_col     <= (r_col == '1) ? r_col : r_col + CNT_W'(1);
            end
          end
        end
        default: r_state <= SYNC_WAIT;
      endcase
    end
  end

  // Two further stages place wen four clocks after the first synchronizer flop sees pclk rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2       <= '0;
      r_wen      <= 1'b0;
      r_pix      <= '0;
      r_waddr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s2  <= r_s1;
      r_wen <= r_s2.keep && !w_addr_full;
      if (r_s2.keep) begin
        if (w_addr_full) r_overflow <= 1'b1;
        else             r_pix      <= r_s2.pix;
      end
      if (w_enter_active) r_waddr <= '0;
      else if (r_wen)     r_waddr <= r_waddr + ADDR_W'(1);
    end
  end

  assign pix_data   = r_pix;
  assign wen        = r_wen;
  assign waddr      = r_waddr;
  assign vsync_out  = w_vs_sync;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_cam_capture.sv
// Randomized scoreboard bench for cam_capture: a small-geometry build and a short-buffer build.
module tb_cam_capture;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 8;
  localparam int unsigned OPIX0 = 32;
  localparam int unsigned OPIX1 = 16;
  localparam int unsigned AW    = 17;

  typedef struct packed {
    logic [15:0]   pix;
    logic [AW-1:0] addr;
    int unsigned   cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;

  logic [15:0]   pix0, pix1;
  logic          wen0, wen1;
  logic [AW-1:0] waddr0, waddr1;
  logic          vso0, vso1;
  logic          fd0, fd1;
  logic          ovf0, ovf1;

  int            tests = 0;
  int            fails = 0;
  int unsigned   cyc = 0;
  int            nfd0 = 0;
  int            nfd1 = 0;

  // Reference model state: 0 idle after reset, 1 between frames, 2 capturing.
  int            m_st = 0;
  int            m_row = 0;
  int            m_frames = 0;
  int            m_addr0 = 0;
  int            m_addr1 = 0;
  bit            m_ovf0 = 0;
  bit            m_ovf1 = 0;
  exp_t          q0[$];
  exp_t          q1[$];

  cam_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .OUT_PIX(OPIX0), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .pix_data(pix0), .wen(wen0),
    .waddr(waddr0), .vsync_out(vso0), .frame_done(fd0), .overflow(ovf0)
  );

  cam_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .OUT_PIX(OPIX1), .ADDR_W(AW)
  ) u_dut_short (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .pix_data(pix1), .wen(wen1),
    .waddr(waddr1), .vsync_out(vso1), .frame_done(fd1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_wen(input int d, input logic [15:0] p, input logic [AW-1:0] a);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL unexpected_wen dut%0d: got pix %h addr %0d at cyc %0d, required no write",
               d, p, a, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (p !== e.pix || a !== e.addr || cyc != e.cyc) begin
        fails++;
        $display("FAIL wen_data dut%0d: got pix %h addr %0d cyc %0d, required pix %h addr %0d cyc %0d",
                 d, p, a, cyc, e.pix, e.addr, e.cyc);
      end
    end
  endtask

  // Monitor: every write strobe is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (fd0 === 1'b1) nfd0++;
    if (fd1 === 1'b1) nfd1++;
    if (wen0 === 1'b1) check_wen(0, pix0, waddr0);
    if (wen1 === 1'b1) check_wen(1, pix1, waddr1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wen"},        {wen0, wen1}, 0);
    chk({tag, "_waddr"},      {waddr0, waddr1}, 0);
    chk({tag, "_pix"},        {pix0, pix1}, 0);
    chk({tag, "_frame_done"}, {fd0, fd1}, 0);
    chk({tag, "_overflow"},   {ovf0, ovf1}, 0);
    chk({tag, "_vsync_out"},  {vso0, vso1}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(1);
    check_zero("midreset");
    m_st   = 0;
    m_ovf0 = 0;
    m_ovf1 = 0;
    q0.delete();
    q1.delete();
    reset = 1'b0;
  endtask

  // A completed pixel at column col of the current model row.
  task automatic model_pixel(input int col, input logic [15:0] pix, input int unsigned c);
    exp_t e;
    if (m_st != 2) return;
    if ((col % 2) != 0 || (m_row % 2) != 0 || col >= int'(H) || m_row >= int'(V)) return;
    e.pix = pix;
    e.cyc = c;
    if (m_addr0 < int'(OPIX0)) begin
      e.addr = AW'(m_addr0);
      q0.push_back(e);
      m_addr0++;
    end else m_ovf0 = 1;
    if (m_addr1 < int'(OPIX1)) begin
      e.addr = AW'(m_addr1);
      q1.push_back(e);
      m_addr1++;
    end else m_ovf1 = 1;
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    if (m_st == 2) m_frames++;
    m_st = 1;
    wait_clk(10);
    chk("vsync_out_high", {vso0, vso1}, 3);
    cam_vsync = 1'b0;
    m_st    = 2;
    m_row   = 0;
    m_addr0 = 0;
    m_addr1 = 0;
    wait_clk(10);
    chk("vsync_out_low", {vso0, vso1}, 0);
  endtask

  // pat 1 sends 0xAB,0xCD repeating; rst_at >= 0 pulses reset before that byte.
  task automatic drive_line(input int nbytes, input int pat, input int rst_at);
    logic [7:0] hi;
    logic [7:0] b;
    hi = '0;
    cam_href = 1'b1;
    wait_clk(3);
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) do_reset();
      if (pat == 1) b = ((i % 2) == 0) ? 8'hAB : 8'hCD;
      else          b = 8'($urandom_range(0, 255));
      cam_data = b;
      wait_clk(3);
      cam_pclk = 1'b1;
      if ((i % 2) == 0) hi = b;
      else              model_pixel(i / 2, {hi, b}, cyc + 5);
      wait_clk(3);
      cam_pclk = 1'b0;
    end
    wait_clk(3);
    cam_href = 1'b0;
    if (m_st == 2 && nbytes > 0) m_row++;
    wait_clk(6);
  endtask

  task automatic end_check(input string tag);
    chk({tag, "_frame_done0"}, nfd0, m_frames);
    chk({tag, "_frame_done1"}, nfd1, m_frames);
    chk({tag, "_overflow0"},   ovf0, m_ovf0);
    chk({tag, "_overflow1"},   ovf1, m_ovf1);
    chk({tag, "_pending0"},    q0.size(), 0);
    chk({tag, "_pending1"},    q1.size(), 0);
  endtask

  initial begin
    int nl;
    reset     = 1'b1;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = '0;
    wait_clk(3);
    check_zero("reset");
    reset = 1'b0;
    wait_clk(5);

    // Lines before any vsync must be ignored.
    drive_line(32, 0, -1);
    vs_pulse();

    // 4 lines x 8 pixels of 0xABCD.
    for (int l = 0; l < 4; l++) drive_line(16, 1, -1);
    vs_pulse();
    end_check("abcd");

    // Exactly full frame: fills the main buffer, overflows the short one.
    for (int l = 0; l < int'(V); l++) drive_line(2 * int'(H), 0, -1);
    vs_pulse();
    end_check("full");

    // Oversized frame: extra rows and columns are dropped silently.
    for (int l = 0; l < int'(V) + 2; l++) drive_line(2 * int'(H) + 4, 0, -1);
    vs_pulse();
    end_check("oversize");

    // Truncated lines leave no half pixel behind.
    drive_line(32, 0, -1);
    drive_line(1, 0, -1);
    drive_line(32, 0, -1);
    drive_line(5, 0, -1);
    drive_line(32, 0, -1);
    drive_line(3, 0, -1);
    drive_line(32, 0, -1);
    vs_pulse();
    end_check("short_lines");

    for (int f = 0; f < 3; f++) begin
      nl = $urandom_range(1, 11);
      for (int l = 0; l < nl; l++) drive_line($urandom_range(0, 36), 0, -1);
      vs_pulse();
      end_check("random");
    end

    // Reset mid-line; nothing is captured until a full vsync high-then-low.
    drive_line(32, 0, -1);
    drive_line(32, 0, -1);
    drive_line(32, 0, 7);
    drive_line(32, 0, -1);
    drive_line(32, 0, -1);
    end_check("after_reset");
    vs_pulse();
    drive_line(32, 0, -1);
    drive_line(32, 0, -1);
    drive_line(32, 0, -1);
    vs_pulse();
    end_check("resume");

    wait_clk(20);
    chk("final_pending0", q0.size(), 0);
    chk("final_pending1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter H_ACTIVE, 640, camera active pixels per line.
REQ-003 Parameter V_ACTIVE, 480, camera active lines per frame.
REQ-004 Parameter ADDR_W, 17, frame buffer address width.
REQ-005 clk  input  1  system clock, at least 4x cam_pclk frequency.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 cam_pclk  input  1  camera pixel clock, sampled as data in the clk domain.
REQ-008 cam_vsync  input  1  camera vertical sync, active high between frames.
REQ-009 cam_href  input  1  camera line valid.
REQ-010 cam_data  input  8  camera byte bus, RGB565, high byte first.
REQ-011 pix_data  output  16  assembled RGB565 pixel.
REQ-012 wen  output  1  one-cycle write strobe for pix_data at waddr.
REQ-013 waddr  output  ADDR_W  frame buffer write address.
REQ-014 vsync_out  output  1  synchronized cam_vsync, for the downstream frame-grab controller.
REQ-015 frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-016 overflow  output  1  sticky flag: pixel dropped because waddr reached OUT_PIX.

Function
REQ-017 cam_pclk, cam_vsync, cam_href and cam_data SHALL each pass through a 2-flop synchronizer; pclk rising edge detected from the synchronized value and its one-cycle delay.
REQ-018 All capture decisions SHALL use only the synchronized, edge-aligned copies of cam_vsync, cam_href and cam_data.
REQ-019 FSM states: SYNC_WAIT, FRAME_WAIT, ACTIVE.
REQ-020 SYNC_WAIT -> FRAME_WAIT on vsync rising edge; no writes in SYNC_WAIT.
REQ-021 FRAME_WAIT -> ACTIVE on vsync falling edge; entering ACTIVE clears byte phase, column and row counters and waddr.
REQ-022 ACTIVE -> FRAME_WAIT on vsync rising edge; frame_done SHALL pulse high for exactly that one clk cycle.
REQ-023 In ACTIVE, each pclk rising edge with href high SHALL toggle byte phase: phase 0 latches cam_data into pix_data[15:8], phase 1 latches pix_data[7:0] and completes a pixel.
REQ-024 Byte phase SHALL clear whenever href is low.
REQ-025 Column counter SHALL increment per completed pixel and clear on href falling edge; row counter SHALL increment on href falling edge.
REQ-026 Decimation 2:1 both axes: a completed pixel is kept only when column[0]==0 and row[0]==0 (320x240 output).
REQ-027 For a kept pixel, wen SHALL be high for exactly one clk cycle, 4 clk cycles after the clk edge at which the synchronizer first captures the pclk rising edge, with pix_data and waddr valid in that cycle.
REQ-028 waddr SHALL increment by 1 in the cycle after each wen and hold otherwise.
REQ-029 When a pixel is kept with waddr == OUT_PIX, wen SHALL stay low, waddr SHALL hold, and overflow SHALL set.
REQ-030 Column counts >= H_ACTIVE or row counts >= V_ACTIVE SHALL produce no write and SHALL NOT set overflow.
REQ-031 overflow SHALL clear only on reset.
REQ-032 Vsync rising while href high SHALL take precedence: frame_done pulses and the partial pixel is discarded.
REQ-033 vsync_out SHALL equal the 2-flop synchronized cam_vsync.

Reset
REQ-034 reset SHALL force state SYNC_WAIT, with all counters, byte phase, synchronizer flops and outputs (pix_data, wen, waddr, vsync_out, frame_done, overflow) at 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; capture SHALL resume only after a full vsync high-then-low sequence.

Structure
REQ-036 Package cam_pkg SHALL hold H_ACTIVE, V_ACTIVE, OUT_PIX=76800, ADDR_W and the FSM state encoding.
REQ-037 The 2-flop synchronizer with rising/falling edge detect SHALL be sub-module cam_sync, instantiated per control input; cam_data uses plain 2-flop synchronizers.

Verification
REQ-038 Reset mid-ACTIVE at pixel 100 -> all outputs 0 next cycle; no wen until vsync 1->0 is seen again.
REQ-039 Frame of 4 lines x 8 pixels, bytes 0xAB,0xCD repeating -> 8 wen total (rows 0,2; cols 0,2,4,6), pix_data=0xABCD, waddr 0..7, one frame_done.
REQ-040 Full 640x480 frame -> 76800 wen, last waddr 76799, overflow=0, frame_done once.
REQ-041 Frame with 482 lines -> 76800 wen, overflow=0 (extra rows ignored); waddr forced to OUT_PIX via shortened OUT_PIX=16 build -> overflow=1, no 17th wen.
REQ-042 href dropped after 1 byte -> no wen, byte phase 0 on next line, following pixel assembled correctly.
REQ-043 Single pclk rise with href high -> wen exactly 4 clk after synchronizer capture, width 1 cycle.
